// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB requester bridge and the APB register files it drives.
package apb_master_pkg;

    localparam int APB_ADDR_WIDTH     = 8;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 2'd0;
    localparam apb_state_t ST_SETUP  = 2'd1;
    localparam apb_state_t ST_ACCESS = 2'd2;
    localparam apb_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus bundle; the bridge drives it through the master modport.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge_watchdog.sv
// Counts ACCESS cycles without pready; flags the cycle on which the transfer must be aborted.
module apb_wait_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    // A zero timeout still needs a 1-bit counter so the design elaborates; tc is then forced low.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TC_VAL = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // Saturating wait-state counter, cleared at the start of every transfer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (TIMEOUT_CYCLES > 0) && (cnt == TC_VAL);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: command channel in, APB transfer out, response channel back.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high, waiting for pready or watchdog abort
// RESP   | response held until rsp_ready
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    apb_master_bridge_if.master   apb
);
    apb_state_t state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_tc;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign wd_clear  = (state == ST_SETUP);
    assign wd_enable = (state == ST_ACCESS) && !apb.pready;

    apb_wait_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .tc     (wd_tc)
    );

    // Transfer sequencing, APB drive and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        apb.paddr   <= cmd_addr;
                        apb.pwrite  <= cmd_write;
                        apb.pwdata  <= cmd_wdata;
                        apb.psel    <= 1'b1;
                        apb.penable <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority so a reply on the terminal cycle completes normally.
                    if (apb.pready) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= apb.pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
                        state       <= ST_RESP;
                    end else if (wd_tc) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized transfers against a latency/response model of the bridge.
module tb_apb_master_bridge;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks   = 0;
    int failures = 0;

    apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) apb_bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer. The slave answers after 'waits' ACCESS cycles without pready.
    task automatic run_txn(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input int waits, input logic err,
                           input logic [31:0] sdata, input int hold);
        int          j;
        int          acc;
        bit          done;
        logic        exp_to;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;

        exp_to  = (TMO > 0) && (waits >= TMO);
        exp_lat = exp_to ? (TMO + 2) : (waits + 3);
        exp_err = exp_to || err;
        exp_rd  = (exp_to || wr) ? 32'h0 : sdata;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        j = 0;
        while (!cmd_ready && j < 20) begin
            @(negedge clk);
            j++;
        end
        check({tag, "_accept"}, cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = $urandom;

        check({tag, "_setup"}, {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, cmd_ready},
              {1'b1, 1'b0, wr, 1'b0});
        check({tag, "_setup_addr_data"}, {apb_bus.paddr, apb_bus.pwdata}, {addr, wdata});

        acc  = 0;
        done = 0;
        j    = 0;
        while (!done && j < TMO + 40) begin
            if (rsp_valid) begin
                done = 1;
            end else begin
                if (apb_bus.psel && apb_bus.penable) begin
                    apb_bus.pready  = (acc == waits);
                    apb_bus.pslverr = (acc == waits) ? err : 1'($urandom);
                    apb_bus.prdata  = (acc == waits) ? sdata : $urandom;
                    acc++;
                end else begin
                    apb_bus.pready  = 1'b0;
                    apb_bus.pslverr = 1'($urandom);
                    apb_bus.prdata  = $urandom;
                end
                @(negedge clk);
                j++;
            end
        end
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        check({tag, "_rsp_seen"}, done, 1'b1);
        check({tag, "_latency"}, j + 1, exp_lat);
        check({tag, "_rsp"}, {rsp_err, rsp_timeout, rsp_rdata}, {exp_err, exp_to, exp_rd});
        check({tag, "_bus_idle"}, {apb_bus.psel, apb_bus.penable, apb_bus.paddr, apb_bus.pwdata},
              {1'b0, 1'b0, addr, wdata});

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold"}, {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready},
                  {1'b1, exp_err, exp_to, exp_rd, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_release"}, {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        int j;
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        apb_bus.prdata  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", cmd_ready, 1'b0);
        check("reset_bus", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, apb_bus.paddr, apb_bus.pwdata},
              {1'b0, 1'b0, 1'b0, 8'h00, 32'h0});
        check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b0, 1'b0, 1'b0, 32'h0});
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1'b1);

        // Directed scenarios
        run_txn("wr_zero_wait", 1'b1, 8'h00, 32'hA5A5_0001, 0, 1'b0, 32'hDEAD_BEEF, 0);
        run_txn("rd_three_wait", 1'b0, 8'h04, 32'h0, 3, 1'b0, 32'h1234_5678, 0);
        run_txn("rd_timeout", 1'b0, 8'h08, 32'h0, 1000, 1'b0, 32'hCAFE_F00D, 0);
        run_txn("wr_slverr_hold", 1'b1, 8'h0C, 32'h5555_AAAA, 0, 1'b1, 32'h0, 5);
        run_txn("rd_terminal_ready", 1'b0, 8'h10, 32'h0, TMO - 1, 1'b0, 32'h0BAD_CAFE, 1);

        // Reset during ACCESS abandons the transfer
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_in_access", {apb_bus.psel, apb_bus.penable}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_bus", {apb_bus.psel, apb_bus.penable, rsp_valid, cmd_ready}, 4'b0000);
        rst = 1'b0;
        j = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) j++;
        end
        check("rst_mid_no_rsp", j, 0);
        run_txn("after_rst", 1'b0, 8'h24, 32'h0, 1, 1'b0, 32'h7777_0001, 0);

        // Randomized traffic
        for (int n = 0; n < 16; n++) begin
            run_txn($sformatf("rand%0d", n), 1'($urandom), 8'($urandom), $urandom,
                    int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
